// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU instruction sequencer: state encoding,
// opcode values, instruction-class tags and IR field positions.
package alu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_T6   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        CLS_REG    = 2'd0,
        CLS_IMM    = 2'd1,
        CLS_MULDIV = 2'd2,
        CLS_UNARY  = 2'd3
    } op_class_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;
    localparam int IR_C_MSB  = 18;

endpackage

// File: rtl/alu_sequencer_ir_decode.sv
// Combinational IR decode: field extraction, register one-hots,
// instruction class, legality and sign-extended immediate.
module alu_sequencer_ir_decode
    import alu_sequencer_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [31:0]         ir_in,
    output logic [4:0]          op,
    output op_class_e           op_class,
    output logic                legal,
    output logic [NUM_REGS-1:0] ra_oh,
    output logic [NUM_REGS-1:0] rb_oh,
    output logic [NUM_REGS-1:0] rc_oh,
    output logic [31:0]         c_sext
);

    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       op_known;
    logic       ra_ok;
    logic       rb_ok;
    logic       rc_ok;

    always_comb begin
        op       = ir_in[IR_OP_MSB:IR_OP_LSB];
        ra       = ir_in[IR_RA_MSB:IR_RA_LSB];
        rb       = ir_in[IR_RB_MSB:IR_RB_LSB];
        rc       = ir_in[IR_RC_MSB:IR_RC_LSB];
        op_known = 1'b1;
        op_class = CLS_REG;

        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: op_class = CLS_REG;
            OP_ADDI, OP_ANDI, OP_ORI:        op_class = CLS_IMM;
            OP_MUL, OP_DIV:                  op_class = CLS_MULDIV;
            OP_NEG, OP_NOT:                  op_class = CLS_UNARY;
            default:                         op_known = 1'b0;
        endcase

        // rc is only a register operand for three-register ops
        ra_ok = 32'(ra) < 32'(NUM_REGS);
        rb_ok = 32'(rb) < 32'(NUM_REGS);
        rc_ok = 32'(rc) < 32'(NUM_REGS);
        legal = op_known && ra_ok && rb_ok && (rc_ok || (op_class != CLS_REG));
    end

    always_comb begin
        ra_oh = '0;
        rb_oh = '0;
        rc_oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            ra_oh[i] = (ra == 4'(i));
            rb_oh[i] = (rb == 4'(i));
            rc_oh[i] = (rc == 4'(i));
        end
    end

    assign c_sext = {{13{ir_in[IR_C_MSB]}}, ir_in[IR_C_MSB:0]};

endmodule

// File: rtl/alu_sequencer.sv
// Control sequencer for a register/ALU datapath: fetches over a ready-gated
// memory read, decodes IR and drives one-hot datapath control per step.
//
// state | meaning
// IDLE  | parked, waiting for run
// T0    | PC to MAR, PC increment
// T1    | memory read into MDR, wait for mem_ready
// T2    | MDR to IR
// T3    | first operand to Y (or unary op to Z); illegal exit
// T4    | second operand / immediate through ALU into Z
// T5    | Z low to destination register or LO
// T6    | Z high to HI (mul/div only)
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [31:0]         ir_in,
    output logic                pc_out,
    output logic                pc_increment,
    output logic                mar_enable,
    output logic                read,
    output logic                mdr_enable,
    output logic                mdr_out,
    output logic                ir_enable,
    output logic                y_enable,
    output logic                z_enable,
    output logic                zlo_out,
    output logic                zhi_out,
    output logic                pc_enable,
    output logic                lo_enable,
    output logic                hi_enable,
    output logic                c_out,
    output logic                illegal,
    output logic                instr_done,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_enable,
    output logic [4:0]          op_code,
    output logic [31:0]         c_sext,
    output logic [CNT_W-1:0]    instr_count
);

    state_e               state_q;
    state_e               state_d;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;

    logic [4:0]           dec_op;
    op_class_e            dec_class;
    logic                 dec_legal;
    logic [NUM_REGS-1:0]  ra_oh;
    logic [NUM_REGS-1:0]  rb_oh;
    logic [NUM_REGS-1:0]  rc_oh;
    logic [31:0]          dec_c_sext;

    alu_sequencer_ir_decode #(
        .NUM_REGS (NUM_REGS)
    ) u_ir_decode (
        .ir_in    (ir_in),
        .op       (dec_op),
        .op_class (dec_class),
        .legal    (dec_legal),
        .ra_oh    (ra_oh),
        .rb_oh    (rb_oh),
        .rc_oh    (rc_oh),
        .c_sext   (dec_c_sext)
    );

    // Held at zero while clr is low so every output clears with the reset
    assign c_sext      = clr ? dec_c_sext : 32'd0;
    assign instr_count = count_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_out       = 1'b0;
        pc_increment = 1'b0;
        mar_enable   = 1'b0;
        read         = 1'b0;
        mdr_enable   = 1'b0;
        mdr_out      = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        z_enable     = 1'b0;
        zlo_out      = 1'b0;
        zhi_out      = 1'b0;
        pc_enable    = 1'b0;
        lo_enable    = 1'b0;
        hi_enable    = 1'b0;
        c_out        = 1'b0;
        illegal      = 1'b0;
        instr_done   = 1'b0;
        reg_out      = '0;
        reg_enable   = '0;
        op_code      = 5'd0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_T0;
            end
            ST_T0: begin
                pc_out       = 1'b1;
                mar_enable   = 1'b1;
                pc_increment = 1'b1;
                state_d      = ST_T1;
            end
            ST_T1: begin
                read       = 1'b1;
                mdr_enable = 1'b1;
                pc_enable  = 1'b1;
                if (mem_ready) state_d = ST_T2;
            end
            ST_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
                state_d   = ST_T3;
            end
            ST_T3: begin
                if (!dec_legal) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = run ? ST_T0 : ST_IDLE;
                end else if (dec_class == CLS_UNARY) begin
                    reg_out  = rb_oh;
                    op_code  = dec_op;
                    z_enable = 1'b1;
                    state_d  = ST_T5;
                end else begin
                    reg_out  = (dec_class == CLS_MULDIV) ? ra_oh : rb_oh;
                    y_enable = 1'b1;
                    state_d  = ST_T4;
                end
            end
            ST_T4: begin
                op_code  = dec_op;
                z_enable = 1'b1;
                case (dec_class)
                    CLS_REG:    reg_out = rc_oh;
                    CLS_IMM:    c_out   = 1'b1;
                    CLS_MULDIV: reg_out = rb_oh;
                    default:    reg_out = '0;
                endcase
                state_d = ST_T5;
            end
            ST_T5: begin
                zlo_out = 1'b1;
                if (dec_class == CLS_MULDIV) begin
                    lo_enable = 1'b1;
                    state_d   = ST_T6;
                end else begin
                    reg_enable = ra_oh;
                    instr_done = 1'b1;
                    state_d    = run ? ST_T0 : ST_IDLE;
                end
            end
            ST_T6: begin
                zhi_out    = 1'b1;
                hi_enable  = 1'b1;
                instr_done = 1'b1;
                state_d    = run ? ST_T0 : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        count_d = count_q;
        if (instr_done && !illegal) count_d = count_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a default instance plus a NUM_REGS=8,
// CNT_W=2 instance sharing all inputs for range-check and wrap cases.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir_in = 32'd0;

    always #5 clk = ~clk;

    logic pc_out, pc_increment, mar_enable, read, mdr_enable, mdr_out, ir_enable;
    logic y_enable, z_enable, zlo_out, zhi_out, pc_enable, lo_enable, hi_enable;
    logic c_out, illegal, instr_done;
    logic [15:0] reg_out, reg_enable, instr_count;
    logic [4:0]  op_code;
    logic [31:0] c_sext;

    logic pc_out_2, pc_increment_2, mar_enable_2, read_2, mdr_enable_2, mdr_out_2, ir_enable_2;
    logic y_enable_2, z_enable_2, zlo_out_2, zhi_out_2, pc_enable_2, lo_enable_2, hi_enable_2;
    logic c_out_2, illegal_2, instr_done_2;
    logic [7:0]  reg_out_2, reg_enable_2;
    logic [1:0]  instr_count_2;
    logic [4:0]  op_code_2;
    logic [31:0] c_sext_2;

    wire [16:0] ctl = {instr_done, illegal, c_out, hi_enable, lo_enable, pc_enable, zhi_out,
                       zlo_out, z_enable, y_enable, ir_enable, mdr_out, mdr_enable, read,
                       mar_enable, pc_increment, pc_out};
    wire [16:0] ctl_2 = {instr_done_2, illegal_2, c_out_2, hi_enable_2, lo_enable_2, pc_enable_2,
                         zhi_out_2, zlo_out_2, z_enable_2, y_enable_2, ir_enable_2, mdr_out_2,
                         mdr_enable_2, read_2, mar_enable_2, pc_increment_2, pc_out_2};

    localparam logic [16:0] K_PC_OUT  = 17'h00001;
    localparam logic [16:0] K_PC_INC  = 17'h00002;
    localparam logic [16:0] K_MAR     = 17'h00004;
    localparam logic [16:0] K_READ    = 17'h00008;
    localparam logic [16:0] K_MDR_EN  = 17'h00010;
    localparam logic [16:0] K_MDR_OUT = 17'h00020;
    localparam logic [16:0] K_IR_EN   = 17'h00040;
    localparam logic [16:0] K_Y_EN    = 17'h00080;
    localparam logic [16:0] K_Z_EN    = 17'h00100;
    localparam logic [16:0] K_ZLO     = 17'h00200;
    localparam logic [16:0] K_ZHI     = 17'h00400;
    localparam logic [16:0] K_PC_EN   = 17'h00800;
    localparam logic [16:0] K_LO      = 17'h01000;
    localparam logic [16:0] K_HI      = 17'h02000;
    localparam logic [16:0] K_C_OUT   = 17'h04000;
    localparam logic [16:0] K_ILL     = 17'h08000;
    localparam logic [16:0] K_DONE    = 17'h10000;
    localparam logic [16:0] K_T0 = K_PC_OUT | K_PC_INC | K_MAR;
    localparam logic [16:0] K_T1 = K_READ | K_MDR_EN | K_PC_EN;
    localparam logic [16:0] K_T2 = K_MDR_OUT | K_IR_EN;

    localparam logic [31:0] IR_SHR  = 32'h4A1B8000;
    localparam logic [31:0] IR_MUL  = 32'h81880000;
    localparam logic [31:0] IR_ADDI = 32'h610FFFFB;
    localparam logic [31:0] IR_NEG  = {5'b10001, 4'd5, 4'd6, 19'd0};
    localparam logic [31:0] IR_ADD9 = {5'b00011, 4'd1, 4'd2, 4'd9, 15'd0};

    int n_cmp = 0;
    int n_bad = 0;

    alu_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir_in(ir_in),
        .pc_out(pc_out), .pc_increment(pc_increment), .mar_enable(mar_enable), .read(read),
        .mdr_enable(mdr_enable), .mdr_out(mdr_out), .ir_enable(ir_enable), .y_enable(y_enable),
        .z_enable(z_enable), .zlo_out(zlo_out), .zhi_out(zhi_out), .pc_enable(pc_enable),
        .lo_enable(lo_enable), .hi_enable(hi_enable), .c_out(c_out), .illegal(illegal),
        .instr_done(instr_done), .reg_out(reg_out), .reg_enable(reg_enable),
        .op_code(op_code), .c_sext(c_sext), .instr_count(instr_count)
    );

    alu_sequencer #(.NUM_REGS(8), .CNT_W(2)) dut_2 (
        .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir_in(ir_in),
        .pc_out(pc_out_2), .pc_increment(pc_increment_2), .mar_enable(mar_enable_2),
        .read(read_2), .mdr_enable(mdr_enable_2), .mdr_out(mdr_out_2), .ir_enable(ir_enable_2),
        .y_enable(y_enable_2), .z_enable(z_enable_2), .zlo_out(zlo_out_2), .zhi_out(zhi_out_2),
        .pc_enable(pc_enable_2), .lo_enable(lo_enable_2), .hi_enable(hi_enable_2),
        .c_out(c_out_2), .illegal(illegal_2), .instr_done(instr_done_2),
        .reg_out(reg_out_2), .reg_enable(reg_enable_2), .op_code(op_code_2),
        .c_sext(c_sext_2), .instr_count(instr_count_2)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        run = 1'b0;
        mem_ready = 1'b1;
        step(2);
        clr = 1'b1;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        step(1);
        n_cmp++; if (ctl !== 17'd0) begin n_bad++; $display("FAIL rst_ctl: got %h want %h", ctl, 17'd0); end
        n_cmp++; if (instr_count !== 16'd0) begin n_bad++; $display("FAIL rst_count: got %h want 0", instr_count); end
        n_cmp++; if (reg_out !== 16'd0 || reg_enable !== 16'd0 || op_code !== 5'd0) begin
            n_bad++; $display("FAIL rst_regsel: got %h/%h/%h want 0", reg_out, reg_enable, op_code); end
        clr = 1'b1;
        run = 1'b0;
        step(2);
        n_cmp++; if (ctl !== 17'd0) begin n_bad++; $display("FAIL idle_no_run: got %h want 0", ctl); end
        run = 1'b1;
        step(1);
        n_cmp++; if (ctl !== K_T0) begin n_bad++; $display("FAIL idle_to_t0: got %h want %h", ctl, K_T0); end
    endtask

    task automatic test_shr();
        do_reset();
        run = 1'b1;
        ir_in = IR_SHR;
        step(1);
        n_cmp++; if (ctl !== K_T0) begin n_bad++; $display("FAIL shr_t0: got %h want %h", ctl, K_T0); end
        step(1);
        n_cmp++; if (ctl !== K_T1) begin n_bad++; $display("FAIL shr_t1: got %h want %h", ctl, K_T1); end
        step(1);
        n_cmp++; if (ctl !== K_T2) begin n_bad++; $display("FAIL shr_t2: got %h want %h", ctl, K_T2); end
        step(1);
        n_cmp++; if (ctl !== K_Y_EN || reg_out !== 16'h0008) begin
            n_bad++; $display("FAIL shr_t3: got %h/%h want %h/0008", ctl, reg_out, K_Y_EN); end
        step(1);
        n_cmp++; if (ctl !== K_Z_EN || reg_out !== 16'h0080 || op_code !== 5'b01001) begin
            n_bad++; $display("FAIL shr_t4: got %h/%h/%b want %h/0080/01001", ctl, reg_out, op_code, K_Z_EN); end
        run = 1'b0;
        step(1);
        n_cmp++; if (ctl !== (K_ZLO | K_DONE) || reg_enable !== 16'h0010) begin
            n_bad++; $display("FAIL shr_t5: got %h/%h want %h/0010", ctl, reg_enable, K_ZLO | K_DONE); end
        step(1);
        n_cmp++; if (ctl !== 17'd0 || instr_count !== 16'd1) begin
            n_bad++; $display("FAIL shr_end: got %h/%0d want 0/1", ctl, instr_count); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        run = 1'b1;
        mem_ready = 1'b0;
        ir_in = IR_SHR;
        step(1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            n_cmp++; if (ctl !== K_T1) begin n_bad++; $display("FAIL wait_t1_%0d: got %h want %h", i, ctl, K_T1); end
            if (i == 3) mem_ready = 1'b1;
        end
        step(1);
        n_cmp++; if (ctl !== K_T2) begin n_bad++; $display("FAIL wait_t2: got %h want %h", ctl, K_T2); end
        run = 1'b0;
        step(4);
        n_cmp++; if (ctl !== 17'd0 || instr_count !== 16'd1) begin
            n_bad++; $display("FAIL wait_end: got %h/%0d want 0/1", ctl, instr_count); end
    endtask

    task automatic test_mul();
        do_reset();
        run = 1'b1;
        ir_in = IR_MUL;
        step(4);
        n_cmp++; if (ctl !== K_Y_EN || reg_out !== 16'h0008) begin
            n_bad++; $display("FAIL mul_t3: got %h/%h want %h/0008", ctl, reg_out, K_Y_EN); end
        step(1);
        n_cmp++; if (ctl !== K_Z_EN || reg_out !== 16'h0002 || op_code !== 5'b10000) begin
            n_bad++; $display("FAIL mul_t4: got %h/%h/%b want %h/0002/10000", ctl, reg_out, op_code, K_Z_EN); end
        step(1);
        n_cmp++; if (ctl !== (K_ZLO | K_LO) || reg_enable !== 16'd0) begin
            n_bad++; $display("FAIL mul_t5: got %h/%h want %h/0000", ctl, reg_enable, K_ZLO | K_LO); end
        run = 1'b0;
        step(1);
        n_cmp++; if (ctl !== (K_ZHI | K_HI | K_DONE) || reg_enable !== 16'd0) begin
            n_bad++; $display("FAIL mul_t6: got %h/%h want %h/0000", ctl, reg_enable, K_ZHI | K_HI | K_DONE); end
        step(1);
        n_cmp++; if (ctl !== 17'd0 || instr_count !== 16'd1) begin
            n_bad++; $display("FAIL mul_end: got %h/%0d want 0/1", ctl, instr_count); end
    endtask

    task automatic test_addi_back_to_back();
        do_reset();
        run = 1'b1;
        ir_in = IR_ADDI;
        step(4);
        n_cmp++; if (ctl !== K_Y_EN || reg_out !== 16'h0002) begin
            n_bad++; $display("FAIL addi_t3: got %h/%h want %h/0002", ctl, reg_out, K_Y_EN); end
        step(1);
        n_cmp++; if (ctl !== (K_Z_EN | K_C_OUT) || reg_out !== 16'd0 || op_code !== 5'b01100) begin
            n_bad++; $display("FAIL addi_t4: got %h/%h/%b want %h/0000/01100", ctl, reg_out, op_code, K_Z_EN | K_C_OUT); end
        n_cmp++; if (c_sext !== 32'hFFFFFFFB) begin n_bad++; $display("FAIL addi_csext: got %h want FFFFFFFB", c_sext); end
        step(1);
        n_cmp++; if (ctl !== (K_ZLO | K_DONE) || reg_enable !== 16'h0004) begin
            n_bad++; $display("FAIL addi_t5: got %h/%h want %h/0004", ctl, reg_enable, K_ZLO | K_DONE); end
        step(1);
        n_cmp++; if (ctl !== K_T0 || instr_count !== 16'd1) begin
            n_bad++; $display("FAIL addi_next: got %h/%0d want %h/1", ctl, instr_count, K_T0); end
        run = 1'b0;
        step(6);
    endtask

    task automatic test_neg();
        do_reset();
        run = 1'b1;
        ir_in = IR_NEG;
        step(4);
        n_cmp++; if (ctl !== K_Z_EN || reg_out !== 16'h0040 || op_code !== 5'b10001) begin
            n_bad++; $display("FAIL neg_t3: got %h/%h/%b want %h/0040/10001", ctl, reg_out, op_code, K_Z_EN); end
        run = 1'b0;
        step(1);
        n_cmp++; if (ctl !== (K_ZLO | K_DONE) || reg_enable !== 16'h0020) begin
            n_bad++; $display("FAIL neg_t5: got %h/%h want %h/0020", ctl, reg_enable, K_ZLO | K_DONE); end
    endtask

    task automatic test_illegal();
        do_reset();
        run = 1'b1;
        ir_in = 32'h00000000;
        step(4);
        n_cmp++; if (ctl !== (K_ILL | K_DONE) || reg_out !== 16'd0 || reg_enable !== 16'd0) begin
            n_bad++; $display("FAIL ld_t3: got %h/%h/%h want %h/0/0", ctl, reg_out, reg_enable, K_ILL | K_DONE); end
        run = 1'b0;
        step(1);
        n_cmp++; if (ctl !== 17'd0 || instr_count !== 16'd0) begin
            n_bad++; $display("FAIL ld_end: got %h/%0d want 0/0", ctl, instr_count); end

        do_reset();
        run = 1'b1;
        ir_in = IR_ADD9;
        step(4);
        n_cmp++; if (ctl_2 !== (K_ILL | K_DONE) || reg_out_2 !== 8'd0) begin
            n_bad++; $display("FAIL rc9_t3_n8: got %h/%h want %h/00", ctl_2, reg_out_2, K_ILL | K_DONE); end
        n_cmp++; if (ctl !== K_Y_EN || reg_out !== 16'h0004) begin
            n_bad++; $display("FAIL rc9_t3_n16: got %h/%h want %h/0004", ctl, reg_out, K_Y_EN); end
        run = 1'b0;
        step(1);
        n_cmp++; if (ctl !== K_Z_EN || reg_out !== 16'h0200 || op_code !== 5'b00011) begin
            n_bad++; $display("FAIL rc9_t4_n16: got %h/%h/%b want %h/0200/00011", ctl, reg_out, op_code, K_Z_EN); end
        n_cmp++; if (ctl_2 !== 17'd0 || instr_count_2 !== 2'd0) begin
            n_bad++; $display("FAIL rc9_end_n8: got %h/%0d want 0/0", ctl_2, instr_count_2); end
        step(1);
        n_cmp++; if (ctl !== (K_ZLO | K_DONE) || reg_enable !== 16'h0002) begin
            n_bad++; $display("FAIL rc9_t5_n16: got %h/%h want %h/0002", ctl, reg_enable, K_ZLO | K_DONE); end
        step(1);
        n_cmp++; if (instr_count !== 16'd1) begin n_bad++; $display("FAIL rc9_count_n16: got %0d want 1", instr_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run = 1'b1;
        ir_in = IR_SHR;
        step(11);
        n_cmp++; if (ctl !== K_Z_EN || instr_count !== 16'd1) begin
            n_bad++; $display("FAIL mid_t4: got %h/%0d want %h/1", ctl, instr_count, K_Z_EN); end
        #2 clr = 1'b0;
        #1;
        n_cmp++; if (ctl !== 17'd0 || reg_out !== 16'd0 || op_code !== 5'd0 || c_sext !== 32'd0) begin
            n_bad++; $display("FAIL mid_async: got %h/%h/%b/%h want all 0", ctl, reg_out, op_code, c_sext); end
        n_cmp++; if (instr_count !== 16'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", instr_count); end
        step(1);
        n_cmp++; if (ctl !== 17'd0) begin n_bad++; $display("FAIL mid_hold: got %h want 0", ctl); end
        clr = 1'b1;
        step(1);
        n_cmp++; if (ctl !== K_T0) begin n_bad++; $display("FAIL mid_restart: got %h want %h", ctl, K_T0); end
        run = 1'b0;
        step(6);
    endtask

    task automatic test_wrap();
        do_reset();
        run = 1'b1;
        ir_in = IR_SHR;
        step(25);
        n_cmp++; if (instr_count !== 16'd4 || instr_count_2 !== 2'd0) begin
            n_bad++; $display("FAIL wrap_four: got %0d/%0d want 4/0", instr_count, instr_count_2); end
        step(5);
        run = 1'b0;
        step(1);
        n_cmp++; if (instr_count !== 16'd5 || instr_count_2 !== 2'd1) begin
            n_bad++; $display("FAIL wrap_five: got %0d/%0d want 5/1", instr_count, instr_count_2); end
        n_cmp++; if (ctl !== 17'd0) begin n_bad++; $display("FAIL wrap_idle: got %h want 0", ctl); end
    endtask

    initial begin
        test_reset();
        test_shr();
        test_mem_wait();
        test_mul();
        test_addi_back_to_back();
        test_neg();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
